burst_memory: RTL and testbench

Parametrised, word-addressed synchronous memory that replaces the fixed single-word processor memory model. It serves instruction fetch and load/store traffic in the MIPS datapath, supports 1/4/8/16-beat bursts selected by `access_size`, reports progress with `busy` and `data_valid`, and maps a configurable base address onto a configurable depth.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_array.sv | 43 ++++
 rtl/burst_memory.sv | 154 +++++++++++++++
 tb/tb_burst_memory.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory: access_size encodings, the burst FSM
// state type and the default memory map used by the fetch and load/store units.
package mem_pkg;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    localparam int          DEFAULT_DATA_WIDTH  = 32;
    localparam int          DEFAULT_ADDR_WIDTH  = 32;
    localparam int          DEFAULT_DEPTH_WORDS = 262144;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h8002_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic logic [4:0] beats_for_size(input logic [1:0] size);
        logic [4:0] beats;
        case (size)
            SIZE_1:  beats = 5'd1;
            SIZE_4:  beats = 5'd4;
            SIZE_8:  beats = 5'd8;
            default: beats = 5'd16;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port; the read register
// resets to zero and holds its value when no read is requested.
module mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 262144,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_memory.sv
// Word-addressed burst memory (1/4/8/16 beats) mapped at BASE_ADDR.
// Define BURST_MEMORY_RANGE_CHECK_EN to flag and suppress out-of-range beats.
module burst_memory
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                    DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef BURST_MEMORY_RANGE_CHECK_EN
    // Keep the full unwrapped word offset so beats past either end are visible.
    localparam int OFF_W = ADDR_WIDTH - SHIFT;
`else
    localparam int OFF_W = IDX_W;
`endif

    state_e           state_d, state_q;
    logic [3:0]       cnt_d, cnt_q;
    logic [OFF_W-1:0] off_d, off_q;
    logic             rw_d, rw_q;
    logic             data_valid_d, data_valid_q;
    logic             error_d, error_q;

    logic [OFF_W-1:0] req_off;
    logic [OFF_W-1:0] beat_off;
    logic [4:0]       req_beats;
    logic             beat_active;
    logic             beat_rw;
    logic             oor;
    logic             ram_we, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_off   = OFF_W'((address - BASE_ADDR) >> SHIFT);
    assign req_beats = beats_for_size(access_size);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        rw_d        = rw_q;
        beat_active = 1'b0;
        beat_rw     = rw_q;
        beat_off    = off_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    beat_active = 1'b1;
                    beat_rw     = rw;
                    beat_off    = req_off;
                    rw_d        = rw;
                    off_d       = req_off + OFF_W'(1);
                    cnt_d       = 4'(req_beats - 5'd1);
                    if (req_beats != 5'd1) begin
                        state_d = ST_BURST;
                    end
                end
            end
            default: begin
                // cnt_q counts the beats still to handle, including this one.
                beat_active = 1'b1;
                off_d       = off_q + OFF_W'(1);
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

`ifdef BURST_MEMORY_RANGE_CHECK_EN
    logic rd_zero_d, rd_zero_q;

    assign oor = |beat_off[OFF_W-1:IDX_W];

    // Out-of-range reads present zero until the next in-range read beat.
    always_comb begin
        rd_zero_d = rd_zero_q;
        if (beat_active && beat_rw) begin
            rd_zero_d = oor;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_zero_q <= 1'b0;
        end else begin
            rd_zero_q <= rd_zero_d;
        end
    end

    assign data_out = rd_zero_q ? '0 : ram_rdata;
`else
    assign oor      = 1'b0;
    assign data_out = ram_rdata;
`endif

    assign ram_we       = beat_active && !beat_rw && !oor;
    assign ram_re       = beat_active &&  beat_rw && !oor;
    assign data_valid_d = beat_active && beat_rw;
    assign error_d      = beat_active && oor;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            rw_q         <= 1'b0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            rw_q         <= rw_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clock  (clock),
        .reset_n(reset_n),
        .we     (ram_we),
        .re     (ram_re),
        .idx    (beat_off[IDX_W-1:0]),
        .wdata  (data_in),
        .rdata  (ram_rdata)
    );

    assign busy       = (state_q == ST_BURST);
    assign data_valid = data_valid_q;
    assign error      = error_q;

endmodule

// File: tb/tb_burst_memory.sv
// Directed self-checking bench for burst_memory with a reduced depth.
module tb_burst_memory;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam logic [31:0] LAST  = BASE + 32'(4 * (DEPTH - 1));

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [1:0]    access_size;
    logic          rw;
    logic          enable;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    burst_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .enable     (enable),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [31:0] a, input logic r, input logic [1:0] sz,
                           input logic [31:0] d);
        address     = a;
        rw          = r;
        access_size = sz;
        data_in     = d;
        enable      = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        rw          = 1'b0;
        address     = '0;
        data_in     = '0;
        access_size = 2'b00;
        #8;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_dout", data_out, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        #4 reset_n = 1'b1;

        // Single write then back-to-back single read
        step();
        request(BASE, 1'b0, 2'b00, 32'hDEAD_BEEF);
        step();
        check("sw_busy", 32'(busy), 32'd0);
        check("sw_valid", 32'(data_valid), 32'd0);
        request(BASE, 1'b1, 2'b00, 32'h0);
        step();
        check("sr_valid", 32'(data_valid), 32'd1);
        check("sr_dout", data_out, 32'hDEAD_BEEF);
        check("sr_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        step();
        check("idle_valid", 32'(data_valid), 32'd0);
        check("idle_hold", data_out, 32'hDEAD_BEEF);

        // 4-beat write with stray enables during busy
        request(BASE + 32'h10, 1'b0, 2'b01, 32'd1);
        for (int k = 1; k < 4; k++) begin
            step();
            check("bw_busy", 32'(busy), 32'd1);
            check("bw_valid", 32'(data_valid), 32'd0);
            request(BASE + 32'h40, 1'b1, 2'b00, 32'(k + 1));
        end
        step();
        check("bw_busy_end", 32'(busy), 32'd0);
        enable = 1'b0;

        // 4-beat read of the same range
        request(BASE + 32'h10, 1'b1, 2'b01, 32'h0);
        step();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check("br_valid", 32'(data_valid), 32'd1);
            check("br_dout", data_out, 32'(k + 1));
            check("br_busy", 32'(busy), (k < 3) ? 32'd1 : 32'd0);
        end
        step();
        check("br_valid_end", 32'(data_valid), 32'd0);
        check("br_hold", data_out, 32'd4);

        // Fill words 0..15, then the last word
        request(BASE, 1'b0, 2'b11, 32'h1000);
        for (int k = 1; k < 16; k++) begin
            step();
            data_in = 32'h1000 + 32'(k);
            enable  = 1'b0;
        end
        step();
        request(LAST, 1'b0, 2'b00, 32'hCAFE_0000);
        step();
        enable = 1'b0;

        // 16-beat read from the last word
        request(LAST, 1'b1, 2'b11, 32'h0);
        step();
        enable = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            check("wr_valid", 32'(data_valid), 32'd1);
`ifdef BURST_MEMORY_RANGE_CHECK_EN
            check("wr_dout", data_out, (k == 0) ? 32'hCAFE_0000 : 32'h0);
            check("wr_error", 32'(error), (k == 0) ? 32'd0 : 32'd1);
`else
            check("wr_dout", data_out, (k == 0) ? 32'hCAFE_0000 : 32'h1000 + 32'(k - 1));
            check("wr_error", 32'(error), 32'd0);
`endif
        end
        step();
        check("wr_busy_end", 32'(busy), 32'd0);

        // Single write just below BASE, then read the last word
        request(32'h8001_FFFC, 1'b0, 2'b00, 32'h5555);
        step();
`ifdef BURST_MEMORY_RANGE_CHECK_EN
        check("lo_error", 32'(error), 32'd1);
`else
        check("lo_error", 32'(error), 32'd0);
`endif
        request(LAST, 1'b1, 2'b00, 32'h0);
        step();
        enable = 1'b0;
        check("lo_valid", 32'(data_valid), 32'd1);
`ifdef BURST_MEMORY_RANGE_CHECK_EN
        check("lo_dout", data_out, 32'hCAFE_0000);
`else
        check("lo_dout", data_out, 32'h5555);
`endif

        // 8-beat read interrupted by reset during beat 5
        request(BASE, 1'b1, 2'b10, 32'h0);
        step();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            check("rr_dout", data_out, 32'h1000 + 32'(k));
            check("rr_busy", 32'(busy), 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("rr_rst_busy", 32'(busy), 32'd0);
        check("rr_rst_valid", 32'(data_valid), 32'd0);
        check("rr_rst_dout", data_out, 32'd0);
        #3 reset_n = 1'b1;
        step();
        check("rr_post_busy", 32'(busy), 32'd0);
        check("rr_post_valid", 32'(data_valid), 32'd0);
        request(BASE + 32'hC, 1'b1, 2'b00, 32'h0);
        step();
        enable = 1'b0;
        check("rr_new_valid", 32'(data_valid), 32'd1);
        check("rr_new_dout", data_out, 32'h1003);
        check("rr_new_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
